muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller for the EX stage; owns the HI/LO registers.
- Accepts mult, multu, div, divu, mfhi, mflo, mthi and mtlo from ID/EX, identified by funct, and sequences an iterative shift-add multiplier or restoring divider.
- Drives a stall request to the hazard unit while an issued op cannot yet complete.
- Sign convention matches the ALU path: signed = ~funct[0].

---
 rtl/muldiv_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative multiply/divide sequencer owning HI/LO (optional MULDIV_EARLY_OUT_EN)
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [5:0]       funct,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_q, acc_d;   // product high half or partial remainder
  logic [WIDTH-1:0]   mq_q, mq_d;     // multiplier/product low half or dividend/quotient
  logic               neg_q, neg_d;   // negate product or quotient in FIX
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               is_mov, is_md, op_signed, op_div, accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_mq;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem, div_quo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0]   rest_mask;
  logic [2*WIDTH-1:0] early_prod;
`endif

  // Instruction decode, operand magnitudes and the per-step datapath.
  always_comb begin
    is_mov    = (funct[5:2] == 4'b0100);
    is_md     = (funct[5:2] == 4'b0110);
    op_signed = ~funct[0];
    op_div    = funct[1];
    accept    = issue & ~busy & ~flush;
    a_neg     = op_signed & rs_data[WIDTH-1];
    b_neg     = op_signed & rt_data[WIDTH-1];
    a_mag     = a_neg ? -rs_data : rs_data;
    b_mag     = b_neg ? -rt_data : rt_data;

    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_acc   = mul_sum[WIDTH:1];
    mul_mq    = {mul_sum[0], mq_q[WIDTH-1:1]};

    div_trial = {acc_q, mq_q[WIDTH-1]} - {1'b0, a_q};
    div_ok    = ~div_trial[WIDTH];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
    div_quo   = {mq_q[WIDTH-2:0], div_ok};

    prod_fix  = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};
    quo_fix   = neg_q ? -mq_q : mq_q;
    rem_fix   = neg_rem_q ? -acc_q : acc_q;
`ifdef MULDIV_EARLY_OUT_EN
    // Low cnt_q bits of the shifted pair still hold unconsumed multiplier bits.
    rest_mask  = ~({WIDTH{1'b1}} << cnt_q);
    early_prod = {mul_acc, mul_mq} >> cnt_q;
`endif
  end

  // Next-state and HI/LO update logic for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (accept && is_md) begin
          a_d        = op_div ? b_mag : a_mag;
          mq_d       = op_div ? a_mag : b_mag;
          acc_d      = '0;
          neg_d      = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          is_div_d   = op_div;
          dz_d       = op_div & (rt_data == '0);
          cnt_d      = CNT_W'(WIDTH - 1);
          div_zero_d = 1'b0;
          state_d    = op_div ? S_DIV : S_MUL;
        end else if (accept && is_mov && funct[0]) begin
          if (funct[1]) lo_d = rs_data;
          else          hi_d = rs_data;
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        mq_d  = mul_mq;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        if ((mul_mq & rest_mask) == '0) begin
          {acc_d, mq_d} = early_prod;
          state_d       = S_FIX;
        end
`endif
      end
      S_DIV: begin
        if (dz_q) begin
          state_d = S_FIX;
        end else begin
          acc_d = div_rem;
          mq_d  = div_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A squash abandons the in-flight op without touching architectural state.
    if (flush && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Output mapping; stall holds the pipeline whenever an op arrives while busy.
  always_comb begin
    busy     = (state_q != S_IDLE);
    stall    = issue & busy;
    done     = done_q;
    div_zero = div_zero_q;
    hi       = hi_q;
    lo       = lo_q;
    rdata    = funct[1] ? lo_q : hi_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue = 1'b0;
  logic [5:0]  funct = 6'b0;
  logic        flush = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] rdata, hi, lo;
  logic        stall, busy, done, div_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, cnt;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .issue(issue), .funct(funct), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .rdata(rdata), .stall(stall),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_mul_lat(input logic [31:0] b, input logic sgn);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int idx;
    m = (sgn && b[31]) ? -b : b;
    idx = 0;
    for (int i = 0; i < 32; i++) if (m[i]) idx = i;
    return idx + 2;
`else
    return (b[0] | sgn) ? 33 : 33;
`endif
  endfunction

  // Issue one op, then count edges until done (bounded; -1 on timeout).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int l);
    funct = f; rs_data = a; rt_data = b; issue = 1'b1;
    step();
    issue = 1'b0;
    l = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (done) begin l = i; break; end
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_dz", {31'b0, div_zero}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    reset = 1'b0;
    step();

    // mthi / mtlo / mfhi / mflo
    funct = F_MTHI; rs_data = 32'h11; issue = 1'b1; #1;
    chk("mthi_nostall", {31'b0, stall}, 32'h0);
    step();
    funct = F_MTLO; rs_data = 32'h22;
    step();
    issue = 1'b0;
    chk("mthi_hi", hi, 32'h11);
    chk("mtlo_lo", lo, 32'h22);
    funct = F_MFHI; #1;
    chk("mfhi_rdata", rdata, 32'h11);
    funct = F_MFLO; #1;
    chk("mflo_rdata", rdata, 32'h22);

    // divide by zero
    run_op(F_DIVU, 32'd5, 32'd0, lat);
    chk("dz_lat", lat, 32'd2);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
    chk("dz_flag", {31'b0, div_zero}, 32'h1);

    // signed / unsigned multiply
    run_op(F_MULT, 32'hFFFFFFFD, 32'd7, lat);
    chk("mult_lat", lat, exp_mul_lat(32'd7, 1'b1));
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    chk("mult_dzclr", {31'b0, div_zero}, 32'h0);
    run_op(F_MULTU, 32'hFFFFFFFD, 32'd7, lat);
    chk("multu_hi", hi, 32'h00000006);
    chk("multu_lo", lo, 32'hFFFFFFEB);

    // signed / unsigned divide
    run_op(F_DIV, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_lat", lat, 32'd33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(F_DIVU, 32'd100, 32'd7, lat);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_dz", {31'b0, div_zero}, 32'h0);
    run_op(F_MULT, 32'h80000000, 32'h80000000, lat);
    chk("minsq_hi", hi, 32'h40000000);
    chk("minsq_lo", lo, 32'h0);

    // mfhi issued while busy stalls until the op completes
    funct = F_MULT; rs_data = 32'h00010000; rt_data = 32'h00030000; issue = 1'b1;
    step();
    issue = 1'b0;
    repeat (4) step();
    funct = F_MFHI; issue = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall) break;
      cnt++;
      step();
    end
    chk("mfhi_stall_cycles", cnt, exp_mul_lat(32'h00030000, 1'b1) - 4);
    chk("mfhi_new_hi", rdata, 32'h3);
    step();
    issue = 1'b0;

    // mtlo issued while busy is held off until after the mult writes LO
    funct = F_MULTU; rs_data = 32'd2; rt_data = 32'd3; issue = 1'b1;
    step();
    issue = 1'b0;
    step();
    funct = F_MTLO; rs_data = 32'hABCD; issue = 1'b1; #1;
    chk("mtlo_stall", {31'b0, stall}, 32'h1);
    chk("mtlo_lo_hold", lo, 32'h0);
    for (int i = 0; i < 100; i++) begin
      if (!stall) break;
      step();
    end
    chk("mtlo_lo_mult", lo, 32'd6);
    step();
    issue = 1'b0;
    chk("mtlo_lo_new", lo, 32'hABCD);
    chk("mtlo_hi", hi, 32'h0);

    // flush mid-divide
    funct = F_DIVU; rs_data = 32'd1000; rt_data = 32'd3; issue = 1'b1;
    step();
    issue = 1'b0;
    repeat (19) step();
    chk("flush_busy_before", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_hi", hi, 32'h0);
    chk("flush_lo", lo, 32'hABCD);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) cnt++;
    end
    chk("flush_nodone", cnt, 32'd0);
    funct = F_MULT; rs_data = 32'd4; rt_data = 32'd4; issue = 1'b1; flush = 1'b1;
    step();
    issue = 1'b0; flush = 1'b0;
    chk("flush_issue_ignored", {31'b0, busy}, 32'h0);
    chk("flush_idle_lo", lo, 32'hABCD);

    // issue during FIX stalls, then is accepted the cycle after
    funct = F_MULTU; rs_data = 32'd2; rt_data = 32'd3; issue = 1'b1;
    step();
    issue = 1'b0;
    repeat (exp_mul_lat(32'd3, 1'b0) - 1) step();
    funct = F_MULTU; rs_data = 32'd5; rt_data = 32'd5; issue = 1'b1; #1;
    chk("fix_stall", {31'b0, stall}, 32'h1);
    step();
    chk("fix_done", {31'b0, done}, 32'h1);
    chk("fix_after_stall", {31'b0, stall}, 32'h0);
    chk("fix_lo", lo, 32'd6);
    step();
    issue = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (done) begin lat = i; break; end
    end
    chk("fix_next_lat", lat, exp_mul_lat(32'd5, 1'b0));
    chk("fix_next_lo", lo, 32'd25);

    // asynchronous reset mid-multiply
    funct = F_MULT; rs_data = 32'h7FFFFFFF; rt_data = 32'h7FFFFFFF; issue = 1'b1;
    step();
    issue = 1'b0;
    repeat (9) step();
    reset = 1'b1; #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    reset = 1'b0;
    step();
    run_op(F_MULT, 32'hFFFFFFFD, 32'd7, lat);
    chk("arst_mult_lat", lat, exp_mul_lat(32'd7, 1'b1));
    chk("arst_mult_lo", lo, 32'hFFFFFFEB);

    // small operands (early-out case when enabled)
    run_op(F_MULT, 32'd3, 32'd5, lat);
    chk("small_lat", lat, exp_mul_lat(32'd5, 1'b1));
    chk("small_lo", lo, 32'd15);
    chk("small_hi", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
